// File: rtl/pixel_scanner.sv
// Raster coordinate generator: walks (x,y) over a PIXEL_W x PIXEL_H frame,
// one pixel per unstalled cycle, with line/frame pulses and a frame counter.
module pixel_scanner #(
  parameter int PIXEL_W = 800,
  parameter int PIXEL_H = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        stall,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [9:0] XMax = 10'(PIXEL_W - 1);
  localparam logic [9:0] YMax = 10'(PIXEL_H - 1);

  state_e      state_q;
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic        valid_q;
  logic        line_q;
  logic        frame_q;
  logic        busy_q;
  logic [15:0] fcnt_q;

  logic last_x;
  logic last_y;

  assign last_x = (x_q == XMax);
  assign last_y = (y_q == YMax);

  // In SCAN valid is always high, so a consumption is simply !stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (!stall) begin
            if (!last_x) begin
              x_q <= x_q + 10'd1;
            end else begin
              x_q    <= '0;
              line_q <= 1'b1;
              if (!last_y) begin
                y_q <= y_q + 10'd1;
              end else begin
                y_q     <= '0;
                frame_q <= 1'b1;
                fcnt_q  <= fcnt_q + 16'd1;
                if (!continuous) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign pixel_valid = valid_q;
  assign line_done   = line_q;
  assign frame_done  = frame_q;
  assign busy        = busy_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_pixel_scanner.sv
// Directed bench for pixel_scanner: 4x3 frame scenarios plus a
// 1024x2 instance exercising the widest legal line.
module tb_pixel_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        line_done;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_count;

  logic        b_start = 1'b0;
  logic [9:0]  b_x;
  logic [9:0]  b_y;
  logic        b_valid;
  logic        b_ld;
  logic        b_fd;
  logic        b_busy;
  logic [15:0] b_fc;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  pixel_scanner #(.PIXEL_W(4), .PIXEL_H(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .continuous(continuous), .stall(stall),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .line_done(line_done),
    .frame_done(frame_done), .busy(busy),
    .frame_count(frame_count)
  );

  pixel_scanner #(.PIXEL_W(1024), .PIXEL_H(2)) dut_big (
    .clk(clk), .rst(rst), .start(b_start),
    .continuous(1'b0), .stall(1'b0),
    .pixel_x(b_x), .pixel_y(b_y),
    .pixel_valid(b_valid), .line_done(b_ld),
    .frame_done(b_fd), .busy(b_busy),
    .frame_count(b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    continuous = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_zero(input string tag);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_x"}, pixel_x, 0);
    chk({tag, "_y"}, pixel_y, 0);
  endtask

  // Walks one 4x3 frame from (0,0); stalls stall_n cycles at index stall_p.
  task automatic scan_frame(input int stall_p, input int stall_n,
                            input bit cont, output int ncyc);
    int p = 0;
    int s = 0;
    ncyc = 0;
    while (p < 12 && ncyc < 100) begin
      chk("valid", pixel_valid, 1);
      chk("busy", busy, 1);
      chk("x", pixel_x, p % 4);
      chk("y", pixel_y, p / 4);
      stall = (p == stall_p) && (s < stall_n);
      continuous = cont;
      tick();
      ncyc++;
      if (stall) begin
        s++;
        chk("ld_stall", line_done, 0);
        chk("fd_stall", frame_done, 0);
      end else begin
        chk("line_done", line_done, (p % 4) == 3);
        chk("frame_done", frame_done, p == 11);
        p++;
      end
    end
    stall = 1'b0;
    continuous = 1'b0;
    if (ncyc >= 100) chk("scan_timeout", ncyc, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_ld", line_done, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_fc", frame_count, 0);
    idle_zero("rst");
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    idle_zero("idle_hold");

    // Single frame, no stall.
    start = 1'b1;
    tick();
    start = 1'b0;
    scan_frame(-1, 0, 1'b0, cyc);
    chk("f1_len", cyc, 12);
    idle_zero("f1_end");
    chk("f1_fc", frame_count, 1);
    tick();
    chk("f1_fd_clear", frame_done, 0);
    idle_zero("f1_idle");

    // Five-cycle stall at (2,1).
    start = 1'b1;
    tick();
    start = 1'b0;
    scan_frame(6, 5, 1'b0, cyc);
    chk("stall_len", cyc, 17);
    chk("stall_fc", frame_count, 2);

    // Continuous: three back-to-back frames, no bubble.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      scan_frame(-1, 0, f < 3, cyc);
      chk("cont_len", cyc, 12);
      chk("cont_fc", frame_count, f);
    end
    idle_zero("cont_end");

    // Reset mid-frame at (1,2).
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_x", pixel_x, 1);
    chk("mid_y", pixel_y, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_zero("mid_rst");
    chk("mid_fd", frame_done, 0);
    chk("mid_fc", frame_count, 0);
    tick();
    chk("mid_fd2", frame_done, 0);
    chk("mid_fc2", frame_count, 0);
    chk("mid_valid2", pixel_valid, 0);

    // Start with stall from IDLE: enter SCAN, hold (0,0).
    start = 1'b1;
    stall = 1'b1;
    tick();
    start = 1'b0;
    chk("ss_valid", pixel_valid, 1);
    tick();
    chk("ss_hold_x", pixel_x, 0);
    chk("ss_hold_y", pixel_y, 0);
    chk("ss_hold_v", pixel_valid, 1);
    stall = 1'b0;
    scan_frame(-1, 0, 1'b0, cyc);
    chk("ss_fc", frame_count, 1);

    // Start held high throughout; re-arm on the frame_done cycle.
    do_reset();
    start = 1'b1;
    tick();
    scan_frame(-1, 0, 1'b0, cyc);
    chk("hold_len", cyc, 12);
    chk("hold_fd", frame_done, 1);
    chk("hold_bubble", pixel_valid, 0);
    tick();
    start = 1'b0;
    chk("hold_restart_v", pixel_valid, 1);
    chk("hold_restart_x", pixel_x, 0);
    chk("hold_restart_y", pixel_y, 0);
    chk("hold_fc", frame_count, 1);
    scan_frame(-1, 0, 1'b0, cyc);
    chk("hold_fc2", frame_count, 2);

    // Widest legal line: 1024 x 2.
    chk("big_idle", b_valid, 0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int p = 0; p < 2048; p++) begin
      chk("big_x", b_x, p % 1024);
      chk("big_y", b_y, p / 1024);
      tick();
      chk("big_ld", b_ld, (p % 1024) == 1023);
    end
    chk("big_fd", b_fd, 1);
    chk("big_valid", b_valid, 0);
    chk("big_busy", b_busy, 0);
    chk("big_fc", b_fc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
